matmul_apb_bridge: RTL and testbench
====================================

MATMUL_APB_BRIDGE -- requirements
Module: matmul_apb_bridge

Interface
REQ-001 Params: DATA_WIDTH 8 (operand element bits); BUS_WIDTH 32 (APB data bits); ADDR_WIDTH 32 (APB address bits); MAX_DIM = BUS_WIDTH/DATA_WIDTH = 4 (max matrix dimension).
REQ-002 Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-003 Ports, in order:
- clk_i  in  1  clock
- rst_i  in  1  sync active-high reset
- psel_i, penable_i, pwrite_i  in  1 each  APB controls
- paddr_i  in  ADDR_WIDTH  APB address
- pwdata_i  in  BUS_WIDTH  APB write data
- pstrb_i  in  MAX_DIM  byte strobes
- prdata_o  out  BUS_WIDTH  APB read data
- pready_o, pslverr_o  out  1 each  APB response
- busy_o  out  1  operation in flight
- start_o  out  1  one-cycle core start pulse
- ctrl_o  out  16  control register
- opa_o, opb_o  out  BUS_WIDTH*MAX_DIM  operand rows A / columns B, flat, line i at [i*BUS_WIDTH +: BUS_WIDTH]
- busy_i, done_i  in  1 each  core status; done_i is a one-cycle pulse
- flags_i  in  BUS_WIDTH  core flags, valid with done_i
- sp_rd_en_o  out  1  scratchpad read request
- sp_sel_o  out  2  scratchpad index
- sp_addr_o  out  2*log2(MAX_DIM)  element index
- sp_rdata_i  in  BUS_WIDTH  scratchpad data, valid one cycle after sp_rd_en_o

Function
REQ-004 Address decode on paddr_i[4:0]: 0x00 CONTROL, 0x04 OPERAND_A, 0x08 OPERAND_B, 0x0C FLAGS, 0x10/0x14/0x18/0x1C SP0..SP3.
REQ-005 Line index: paddr_i[5 +: log2(MAX_DIM)] for operands; paddr_i[5 +: 2*log2(MAX_DIM)] for SP element.
REQ-006 FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP on psel_i & !penable_i.
- SETUP -> ACCESS unconditionally.
- ACCESS -> SETUP if psel_i & !penable_i is sampled in ACCESS; otherwise ACCESS -> IDLE.
REQ-007 Zero wait states: pready_o = 1 only in the ACCESS cycle, 0 otherwise.
REQ-008 pslverr_o = 1 only in an ACCESS cycle whose transaction is illegal; 0 otherwise (never held between transactions).
REQ-009 Illegal transactions:
- paddr_i[1:0] != 0;
- write to FLAGS or any SP;
- write to CONTROL/OPERAND_A/OPERAND_B while busy_o = 1.
An illegal access changes no state.
REQ-010 Write commit at ACCESS, per byte lane where pstrb_i[b] = 1; lanes with pstrb_i[b] = 0 are unchanged.
REQ-011 SP read: sp_rd_en_o is a one-cycle pulse in SETUP with sp_sel_o/sp_addr_o decoded; prdata_o = sp_rdata_i during ACCESS.
REQ-012 Read data during ACCESS: CONTROL, operand line, and FLAGS registers returned directly; prdata_o = 0 outside ACCESS and on an illegal read.
REQ-013 CONTROL field layout: [0] start, [1] mode, [3:2] write target, [5:4] read target, [9:8] N-1, [11:10] K-1, [13:12] M-1; bits [7:6], [15:14] and bits above 15 read 0.
REQ-014 Start: a legal CONTROL write with start = 1 drives start_o high the cycle after ACCESS. ctrl_o[0] self-clears in that same cycle.
REQ-015 busy_o = start_o | busy_i | pending, where pending sets with start_o and clears on the first cycle busy_i = 1.
REQ-016 FLAGS register loads flags_i on done_i and holds otherwise. done_i in the same cycle as a FLAGS read returns the new value.
REQ-017 psel_i dropped mid-transaction: return to IDLE, no commit.

Reset
REQ-018 With rst_i = 1 at a clk_i edge: FSM -> IDLE; all registers, operand buffers and FLAGS -> 0; every output = 0 the following cycle. Reset mid-transaction aborts it with no commit.

Structure
REQ-019 matmul_pkg holds DATA_WIDTH, BUS_WIDTH, ADDR_WIDTH, MAX_DIM, the address-map constants, the CONTROL field offsets, and the FSM state enum.
REQ-020 A single sub-module, matmul_apb_regfile, holds the byte-strobed operand/control storage; the FSM and decode live in the top.

Verification
REQ-021 Write OPERAND_A line 2 = 0x04030201, pstrb 1111 -> opa_o[95:64] = 0x04030201, pready_o = 1 on the 3rd edge, pslverr_o = 0.
REQ-022 Write CONTROL = 0x2A27 -> start_o pulses one cycle; ctrl_o = 0x2A26; busy_o = 1 until busy_i falls.
REQ-023 While busy_i = 1, write OPERAND_B = 0xFFFFFFFF -> pslverr_o = 1 for the ACCESS cycle only; opb_o unchanged.
REQ-024 Read SP2 element 5 -> sp_rd_en_o pulses in SETUP with sp_sel_o = 2, sp_addr_o = 5; prdata_o = sp_rdata_i in ACCESS.
REQ-025 done_i with flags_i = 0x3, then read FLAGS -> 0x3; write FLAGS -> pslverr_o = 1, value stays 0x3.
REQ-026 rst_i asserted in the ACCESS cycle of a CONTROL write -> no start_o pulse; ctrl_o = 0; FSM in IDLE.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, register map and FSM encoding for the
// matrix-multiply APB bridge.
package matmul_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned BUS_WIDTH  = 32;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W      = $clog2(MAX_DIM);
    localparam int unsigned SP_AW      = 2 * IDX_W;

    localparam logic [4:0] ADDR_CONTROL = 5'h00;
    localparam logic [4:0] ADDR_OPA     = 5'h04;
    localparam logic [4:0] ADDR_OPB     = 5'h08;
    localparam logic [4:0] ADDR_FLAGS   = 5'h0C;
    localparam logic [4:0] ADDR_SP0     = 5'h10;
    localparam logic [4:0] ADDR_SP1     = 5'h14;
    localparam logic [4:0] ADDR_SP2     = 5'h18;
    localparam logic [4:0] ADDR_SP3     = 5'h1C;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_MODE   = 1;
    localparam int unsigned CTRL_WR_TGT = 2;
    localparam int unsigned CTRL_RD_TGT = 4;
    localparam int unsigned CTRL_N      = 8;
    localparam int unsigned CTRL_K      = 10;
    localparam int unsigned CTRL_M      = 12;

    // Start never persists in storage; reserved bits read back as zero.
    localparam logic [15:0] CTRL_WMASK = 16'h3F3E;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } apb_state_e;

    function automatic logic [BUS_WIDTH-1:0] byte_merge(
        input logic [BUS_WIDTH-1:0] old_v,
        input logic [BUS_WIDTH-1:0] new_v,
        input logic [MAX_DIM-1:0]   strb
    );
        logic [BUS_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < int'(MAX_DIM); b++) begin
            if (strb[b]) begin
                r[b*DATA_WIDTH +: DATA_WIDTH] = new_v[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_apb_regfile.sv
// Byte-strobed storage for the CONTROL register and the
// operand A rows / operand B columns.
module matmul_apb_regfile
    import matmul_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ctrl_we_i,
    input  logic                         opa_we_i,
    input  logic                         opb_we_i,
    input  logic [IDX_W-1:0]             line_i,
    input  logic [BUS_WIDTH-1:0]         wdata_i,
    input  logic [MAX_DIM-1:0]           strb_i,
    output logic [15:0]                  ctrl_o,
    output logic [BUS_WIDTH*MAX_DIM-1:0] opa_o,
    output logic [BUS_WIDTH*MAX_DIM-1:0] opb_o
);

    logic [15:0]                         ctrl_q;
    logic [15:0]                         ctrl_d;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0]   opa_q;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0]   opb_q;

    // Merge the two low byte lanes into CONTROL and drop non-storable bits.
    always_comb begin
        ctrl_d = ctrl_q;
        for (int b = 0; b < 2; b++) begin
            if (strb_i[b]) begin
                ctrl_d[b*DATA_WIDTH +: DATA_WIDTH] = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ctrl_d = ctrl_d & CTRL_WMASK;
    end

    // Commit strobed writes; reset wins over any pending commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
        end else begin
            if (ctrl_we_i) begin
                ctrl_q <= ctrl_d;
            end
            if (opa_we_i) begin
                opa_q[line_i] <= byte_merge(opa_q[line_i], wdata_i, strb_i);
            end
            if (opb_we_i) begin
                opb_q[line_i] <= byte_merge(opb_q[line_i], wdata_i, strb_i);
            end
        end
    end

    assign ctrl_o = ctrl_q;
    assign opa_o  = opa_q;
    assign opb_o  = opb_q;

endmodule

// File: rtl/matmul_apb_bridge.sv
// APB slave front end for the matrix-multiply core: decode,
// transfer FSM, start/busy tracking, FLAGS and scratchpad reads.
module matmul_apb_bridge
    import matmul_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [ADDR_WIDTH-1:0]        paddr_i,
    input  logic [BUS_WIDTH-1:0]         pwdata_i,
    input  logic [MAX_DIM-1:0]           pstrb_i,
    output logic [BUS_WIDTH-1:0]         prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    output logic                         busy_o,
    output logic                         start_o,
    output logic [15:0]                  ctrl_o,
    output logic [BUS_WIDTH*MAX_DIM-1:0] opa_o,
    output logic [BUS_WIDTH*MAX_DIM-1:0] opb_o,
    input  logic                         busy_i,
    input  logic                         done_i,
    input  logic [BUS_WIDTH-1:0]         flags_i,
    output logic                         sp_rd_en_o,
    output logic [1:0]                   sp_sel_o,
    output logic [SP_AW-1:0]             sp_addr_o,
    input  logic [BUS_WIDTH-1:0]         sp_rdata_i
);

    apb_state_e           state_q;
    logic                 pready_q;
    logic                 start_q;
    logic                 pending_q;
    logic                 sp_rd_en_q;
    logic [1:0]           sp_sel_q;
    logic [SP_AW-1:0]     sp_addr_q;
    logic [BUS_WIDTH-1:0] flags_q;

    logic [4:0]           reg_off;
    logic [IDX_W-1:0]     line;
    logic [SP_AW-1:0]     sp_idx;
    logic                 misal;
    logic                 is_ctrl;
    logic                 is_opa;
    logic                 is_opb;
    logic                 is_flags;
    logic                 is_sp;
    logic                 illegal;
    logic                 setup_req;
    logic                 xfer;
    logic                 commit;
    logic                 sp_req;
    logic                 start_wr;
    logic                 unused_addr;

    assign reg_off     = paddr_i[4:0];
    assign line        = paddr_i[5 +: IDX_W];
    assign sp_idx      = paddr_i[5 +: SP_AW];
    assign unused_addr = ^paddr_i[ADDR_WIDTH-1:5+SP_AW];

    assign misal    = |paddr_i[1:0];
    assign is_ctrl  = reg_off == ADDR_CONTROL;
    assign is_opa   = reg_off == ADDR_OPA;
    assign is_opb   = reg_off == ADDR_OPB;
    assign is_flags = reg_off == ADDR_FLAGS;
    assign is_sp    = reg_off[4] & ~misal;

    assign busy_o  = start_q | busy_i | pending_q;

    // Read-only targets and writes to core-facing state while busy are refused.
    assign illegal = misal
                   | (pwrite_i & (is_flags | is_sp))
                   | (pwrite_i & busy_o & (is_ctrl | is_opa | is_opb));

    assign setup_req = psel_i & ~penable_i;
    assign xfer      = (state_q == S_ACCESS) & psel_i & penable_i;
    assign commit    = xfer & pwrite_i & ~illegal;
    assign sp_req    = setup_req & ~pwrite_i & is_sp;
    assign start_wr  = commit & is_ctrl & pstrb_i[0] & pwdata_i[CTRL_START];

    matmul_apb_regfile u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ctrl_we_i (commit & is_ctrl),
        .opa_we_i  (commit & is_opa),
        .opb_we_i  (commit & is_opb),
        .line_i    (line),
        .wdata_i   (pwdata_i),
        .strb_i    (pstrb_i),
        .ctrl_o    (ctrl_o),
        .opa_o     (opa_o),
        .opb_o     (opb_o)
    );

    // Transfer FSM with registered handshake, start and scratchpad request outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pready_q   <= 1'b0;
            start_q    <= 1'b0;
            pending_q  <= 1'b0;
            sp_rd_en_q <= 1'b0;
            sp_sel_q   <= '0;
            sp_addr_q  <= '0;
        end else begin
            pready_q   <= 1'b0;
            start_q    <= 1'b0;
            sp_rd_en_q <= 1'b0;
            sp_sel_q   <= '0;
            sp_addr_q  <= '0;
            if (busy_i) begin
                pending_q <= 1'b0;
            end else if (start_q) begin
                pending_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (setup_req) begin
                        state_q    <= S_SETUP;
                        sp_rd_en_q <= sp_req;
                        sp_sel_q   <= sp_req ? paddr_i[3:2] : 2'b00;
                        sp_addr_q  <= sp_req ? sp_idx : '0;
                    end
                end
                S_SETUP: begin
                    if (!psel_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q  <= S_ACCESS;
                        pready_q <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    start_q <= start_wr;
                    if (setup_req) begin
                        state_q    <= S_SETUP;
                        sp_rd_en_q <= sp_req;
                        sp_sel_q   <= sp_req ? paddr_i[3:2] : 2'b00;
                        sp_addr_q  <= sp_req ? sp_idx : '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FLAGS capture the core status on each done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else if (done_i) begin
            flags_q <= flags_i;
        end
    end

    // Read mux; a done pulse coinciding with a FLAGS read forwards the new value.
    always_comb begin
        prdata_o = '0;
        if (xfer & ~pwrite_i & ~illegal) begin
            unique case (1'b1)
                is_ctrl:  prdata_o = {{(BUS_WIDTH-16){1'b0}}, ctrl_o};
                is_opa:   prdata_o = opa_o[int'(line)*BUS_WIDTH +: BUS_WIDTH];
                is_opb:   prdata_o = opb_o[int'(line)*BUS_WIDTH +: BUS_WIDTH];
                is_flags: prdata_o = done_i ? flags_i : flags_q;
                is_sp:    prdata_o = sp_rdata_i;
                default:  prdata_o = '0;
            endcase
        end
    end

    assign pready_o   = pready_q;
    assign pslverr_o  = xfer & illegal;
    assign start_o    = start_q;
    assign sp_rd_en_o = sp_rd_en_q;
    assign sp_sel_o   = sp_sel_q;
    assign sp_addr_o  = sp_addr_q;

endmodule

// File: tb/tb_matmul_apb_bridge.sv
// Directed self-checking bench for matmul_apb_bridge.
// Linear APB sequence with hand-computed expectations.
module tb_matmul_apb_bridge;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         psel_i = 1'b0;
    logic         penable_i = 1'b0;
    logic         pwrite_i = 1'b0;
    logic [31:0]  paddr_i = '0;
    logic [31:0]  pwdata_i = '0;
    logic [3:0]   pstrb_i = '0;
    logic [31:0]  prdata_o;
    logic         pready_o;
    logic         pslverr_o;
    logic         busy_o;
    logic         start_o;
    logic [15:0]  ctrl_o;
    logic [127:0] opa_o;
    logic [127:0] opb_o;
    logic         busy_i = 1'b0;
    logic         done_i = 1'b0;
    logic [31:0]  flags_i = '0;
    logic         sp_rd_en_o;
    logic [1:0]   sp_sel_o;
    logic [3:0]   sp_addr_o;
    logic [31:0]  sp_rdata_i = '0;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  rd;
    logic         err;
    int           lat;
    logic         sp_en_s;
    logic [1:0]   sp_sel_s;
    logic [3:0]   sp_addr_s;
    logic         inj_done = 1'b0;
    logic [31:0]  inj_flags = '0;
    logic         seen;

    always #5 clk_i = ~clk_i;

    matmul_apb_bridge dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .psel_i     (psel_i),
        .penable_i  (penable_i),
        .pwrite_i   (pwrite_i),
        .paddr_i    (paddr_i),
        .pwdata_i   (pwdata_i),
        .pstrb_i    (pstrb_i),
        .prdata_o   (prdata_o),
        .pready_o   (pready_o),
        .pslverr_o  (pslverr_o),
        .busy_o     (busy_o),
        .start_o    (start_o),
        .ctrl_o     (ctrl_o),
        .opa_o      (opa_o),
        .opb_o      (opb_o),
        .busy_i     (busy_i),
        .done_i     (done_i),
        .flags_i    (flags_i),
        .sp_rd_en_o (sp_rd_en_o),
        .sp_sel_o   (sp_sel_o),
        .sp_addr_o  (sp_addr_o),
        .sp_rdata_i (sp_rdata_i)
    );

    // Scratchpad model: data one cycle after the request, tagged with sel/addr.
    always @(posedge clk_i) begin
        if (sp_rd_en_o)
            sp_rdata_i <= 32'hC0DE0000 | {26'b0, sp_sel_o, sp_addr_o};
        else
            sp_rdata_i <= 32'hDEADBEEF;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r, output logic e,
                       output int l);
        r = '0;
        e = 1'b0;
        l = -1;
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = w;
        paddr_i = a; pwdata_i = d; pstrb_i = s;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (i == 0) begin
                sp_en_s = sp_rd_en_o;
                sp_sel_s = sp_sel_o;
                sp_addr_s = sp_addr_o;
            end
            if (pready_o) begin
                l = i;
                r = prdata_o;
                e = pslverr_o;
                break;
            end
            @(posedge clk_i); #1;
            if (i == 0) begin
                done_i = inj_done;
                flags_i = inj_flags;
            end
        end
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0; done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_pready", pready_o, 1'b0);
        chk("rst_pslverr", pslverr_o, 1'b0);
        chk("rst_prdata", prdata_o, 32'h0);
        chk("rst_busy_start", {busy_o, start_o, sp_rd_en_o}, 3'b000);
        chk("rst_ctrl", ctrl_o, 16'h0);
        chk("rst_opa", opa_o, 128'h0);
        chk("rst_opb", opb_o, 128'h0);

        apb(1'b1, 32'h44, 32'h04030201, 4'hF, rd, err, lat);
        chk("opa_wr_lat", lat, 1);
        chk("opa_wr_err", err, 1'b0);
        chk("opa_line2", opa_o[95:64], 32'h04030201);
        chk("opa_other", {opa_o[127:96], opa_o[63:0]}, 96'h0);

        apb(1'b1, 32'h44, 32'hAABBCCDD, 4'b0101, rd, err, lat);
        chk("opa_strb", opa_o[95:64], 32'h04BB02DD);
        apb(1'b0, 32'h44, 32'h0, 4'h0, rd, err, lat);
        chk("opa_rd", rd, 32'h04BB02DD);

        apb(1'b1, 32'h08, 32'h11223344, 4'hF, rd, err, lat);
        chk("opb_line0", opb_o[31:0], 32'h11223344);

        apb(1'b0, 32'h02, 32'h0, 4'h0, rd, err, lat);
        chk("misal_rd_err", err, 1'b1);
        chk("misal_rd_data", rd, 32'h0);
        apb(1'b1, 32'h45, 32'h0, 4'hF, rd, err, lat);
        chk("misal_wr_err", err, 1'b1);
        chk("misal_wr_keep", opa_o[95:64], 32'h04BB02DD);

        apb(1'b1, 32'h00, 32'h00002A27, 4'b0011, rd, err, lat);
        chk("ctrl_wr_err", err, 1'b0);
        chk("start_pulse", start_o, 1'b1);
        chk("ctrl_val", ctrl_o, 16'h2A26);
        chk("busy_start", busy_o, 1'b1);
        @(posedge clk_i); #1;
        chk("start_one_cycle", start_o, 1'b0);
        chk("busy_pending", busy_o, 1'b1);
        busy_i = 1'b1;
        @(posedge clk_i); #1;
        chk("busy_core", busy_o, 1'b1);

        apb(1'b0, 32'h00, 32'h0, 4'h0, rd, err, lat);
        chk("ctrl_rd", rd, 32'h00002A26);
        apb(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, rd, err, lat);
        chk("busy_wr_err", err, 1'b1);
        chk("busy_wr_keep", opb_o[31:0], 32'h11223344);
        chk("slverr_drop", pslverr_o, 1'b0);
        apb(1'b1, 32'h00, 32'h00000001, 4'hF, rd, err, lat);
        chk("busy_ctrl_err", err, 1'b1);
        chk("busy_ctrl_keep", {start_o, ctrl_o}, {1'b0, 16'h2A26});
        busy_i = 1'b0;
        #1;
        chk("busy_clear", busy_o, 1'b0);

        apb(1'b1, 32'h00, 32'hFFFFFFFE, 4'hF, rd, err, lat);
        chk("ctrl_rsvd", {start_o, ctrl_o}, {1'b0, 16'h3F3E});
        apb(1'b0, 32'h00, 32'h0, 4'h0, rd, err, lat);
        chk("ctrl_rsvd_rd", rd, 32'h00003F3E);

        apb(1'b0, 32'hB8, 32'h0, 4'h0, rd, err, lat);
        chk("sp_setup", {sp_en_s, sp_sel_s, sp_addr_s}, {1'b1, 2'd2, 4'd5});
        chk("sp_rd", rd, 32'hC0DE0025);
        chk("sp_rd_err", err, 1'b0);
        chk("sp_pulse_end", sp_rd_en_o, 1'b0);
        apb(1'b1, 32'h14, 32'h12345678, 4'hF, rd, err, lat);
        chk("sp_wr_err", err, 1'b1);

        @(posedge clk_i); #1;
        done_i = 1'b1; flags_i = 32'h3;
        @(posedge clk_i); #1;
        done_i = 1'b0; flags_i = 32'hFFFF;
        apb(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, lat);
        chk("flags_rd", rd, 32'h3);
        apb(1'b1, 32'h0C, 32'hFF, 4'hF, rd, err, lat);
        chk("flags_wr_err", err, 1'b1);
        apb(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, lat);
        chk("flags_keep", rd, 32'h3);
        inj_done = 1'b1; inj_flags = 32'h5A;
        apb(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, lat);
        chk("flags_fwd", rd, 32'h5A);
        inj_done = 1'b0; inj_flags = 32'h0;
        apb(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, lat);
        chk("flags_loaded", rd, 32'h5A);

        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
        paddr_i = 32'h0; pwdata_i = 32'h00002A27; pstrb_i = 4'b0011;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_in_access", pready_o, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        chk("rst_abort", {start_o, pready_o, ctrl_o}, {1'b0, 1'b0, 16'h0});
        chk("rst_abort_opa", opa_o, 128'h0);
        @(posedge clk_i); #1;
        chk("rst_no_start", {start_o, busy_o}, 2'b00);
        apb(1'b0, 32'h00, 32'h0, 4'h0, rd, err, lat);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_ctrl", rd, 32'h0);

        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
        paddr_i = 32'h24; pwdata_i = 32'hCAFEBABE; pstrb_i = 4'hF;
        @(posedge clk_i); #1;
        psel_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            seen = seen | pready_o;
        end
        chk("drop_no_ready", seen, 1'b0);
        chk("drop_no_commit", opa_o[63:32], 32'h0);
        apb(1'b0, 32'h24, 32'h0, 4'h0, rd, err, lat);
        chk("drop_recover", {lat[1:0], rd}, {2'd1, 32'h0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
